// File: rtl/comparador_troco.sv
// Clocked price comparator for the vending machine: accumulates coins, checks the
// selected product's price and dispenses or refunds. `define TROCO_EN enables change on overpayment.
module comparador_troco #(
    parameter int unsigned VALOR_W      = 8,
    parameter int unsigned MOEDA_W      = 4,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned NUM_PRODUTOS = 6,
    parameter logic [NUM_PRODUTOS*VALOR_W-1:0] PRECOS = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd2},
    parameter int unsigned TIMEOUT      = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               moedaValida,
    input  logic [MOEDA_W-1:0] valorMoeda,
    input  logic               selecionar,
    input  logic [SEL_W-1:0]   valorProduto,
    input  logic               cancelar,
    output logic               ocupado,
    output logic               liberarProduto,
    output logic               devolverMoedas,
    output logic [VALOR_W-1:0] valorDevolvido,
    output logic [VALOR_W-1:0] valorTotal,
    output logic               moedaRejeitada
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        OCIOSO,
        ACUMULANDO,
        COMPARANDO,
        LIBERANDO,
        DEVOLVENDO
    } estado_t;

    estado_t            estado, estado_n;
    logic [VALOR_W-1:0] total, total_n;
    logic [VALOR_W-1:0] troco, troco_n;
    logic [SEL_W-1:0]   produto, produto_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               rejeita, rejeita_n;

    logic [VALOR_W:0]   soma;
    logic [VALOR_W-1:0] preco;
    logic               produto_valido;
    logic               aceita;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado  <= OCIOSO;
            total   <= '0;
            troco   <= '0;
            produto <= '0;
            cnt     <= '0;
            rejeita <= 1'b0;
        end else begin
            estado  <= estado_n;
            total   <= total_n;
            troco   <= troco_n;
            produto <= produto_n;
            cnt     <= cnt_n;
            rejeita <= rejeita_n;
        end
    end

    always_comb begin
        preco          = '0;
        produto_valido = 1'b0;
        for (int unsigned k = 1; k <= NUM_PRODUTOS; k++) begin
            if (32'(produto) == k) begin
                preco          = PRECOS[(k-1)*VALOR_W +: VALOR_W];
                produto_valido = 1'b1;
            end
        end
    end

    // Extra MSB of the sum flags a coin that would overflow the credit register.
    assign soma = {1'b0, total} + {{(VALOR_W + 1 - MOEDA_W){1'b0}}, valorMoeda};

    always_comb begin
        estado_n  = estado;
        total_n   = total;
        troco_n   = troco;
        produto_n = produto;
        cnt_n     = '0;
        rejeita_n = 1'b0;
        aceita    = 1'b0;
        case (estado)
            OCIOSO, ACUMULANDO: begin
                aceita    = moedaValida && !cancelar && !soma[VALOR_W];
                rejeita_n = moedaValida && !aceita;
                if (aceita)
                    total_n = soma[VALOR_W-1:0];
                if (estado == ACUMULANDO)
                    cnt_n = (aceita || cnt == CNT_W'(TIMEOUT - 1)) ? '0 : cnt + 1'b1;
                // Coin is folded in first, so a same-cycle select compares against the new sum.
                if (cancelar) begin
                    if (estado == ACUMULANDO)
                        estado_n = DEVOLVENDO;
                end else if (selecionar && (estado == ACUMULANDO || total_n != '0)) begin
                    produto_n = valorProduto;
                    estado_n  = COMPARANDO;
                end else if (aceita) begin
                    estado_n = ACUMULANDO;
                end else if (estado == ACUMULANDO && cnt == CNT_W'(TIMEOUT - 1)) begin
                    estado_n = DEVOLVENDO;
                end
            end
            COMPARANDO: begin
                rejeita_n = moedaValida;
                troco_n   = '0;
                if (produto_valido && total == preco)
                    estado_n = LIBERANDO;
`ifdef TROCO_EN
                else if (produto_valido && total > preco) begin
                    estado_n = LIBERANDO;
                    troco_n  = total - preco;
                end
`endif
                else
                    estado_n = DEVOLVENDO;
            end
            LIBERANDO, DEVOLVENDO: begin
                rejeita_n = moedaValida;
                total_n   = '0;
                troco_n   = '0;
                estado_n  = OCIOSO;
            end
            default: estado_n = OCIOSO;
        endcase
        if (estado_n != ACUMULANDO)
            cnt_n = '0;
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    assign ocupado        = (estado == COMPARANDO) || (estado == LIBERANDO) || (estado == DEVOLVENDO);
    assign liberarProduto = (estado == LIBERANDO);
    assign devolverMoedas = (estado == DEVOLVENDO) || (estado == LIBERANDO && troco != '0);
    assign valorDevolvido = (estado == LIBERANDO)  ? troco :
                            (estado == DEVOLVENDO) ? total : '0;
    assign valorTotal     = total;
    assign moedaRejeitada = rejeita;

endmodule

// File: tb/tb_comparador_troco.sv
// Scoreboard bench for comparador_troco: directed stimulus pushes expected output
// events; a negedge monitor pops and compares every pulse the DUT presents.
module tb_comparador_troco;

    localparam int unsigned TIMEOUT = 1000;

    typedef struct packed {
        logic       lib;
        logic       dev;
        logic       rej;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       moedaValida = 1'b0;
    logic [3:0] valorMoeda = '0;
    logic       selecionar = 1'b0;
    logic [2:0] valorProduto = '0;
    logic       cancelar = 1'b0;
    logic       ocupado, liberarProduto, devolverMoedas, moedaRejeitada;
    logic [7:0] valorDevolvido, valorTotal;

    int   chk_total = 0;
    int   chk_pass  = 0;
    ev_t  q[$];
    ev_t  got, expv;

    comparador_troco #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .moedaValida   (moedaValida),
        .valorMoeda    (valorMoeda),
        .selecionar    (selecionar),
        .valorProduto  (valorProduto),
        .cancelar      (cancelar),
        .ocupado       (ocupado),
        .liberarProduto(liberarProduto),
        .devolverMoedas(devolverMoedas),
        .valorDevolvido(valorDevolvido),
        .valorTotal    (valorTotal),
        .moedaRejeitada(moedaRejeitada)
    );

    always #5 clk = ~clk;

    function automatic ev_t ev(input logic l, input logic d, input logic r, input logic [7:0] v);
        ev_t e;
        e.lib = l; e.dev = d; e.rej = r; e.val = v;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && (liberarProduto || devolverMoedas || moedaRejeitada)) begin
            got = ev(liberarProduto, devolverMoedas, moedaRejeitada, valorDevolvido);
            chk_total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_event: got lib=%0b dev=%0b rej=%0b val=%0d, expected none",
                         got.lib, got.dev, got.rej, got.val);
            end else begin
                expv = q.pop_front();
                if (got === expv)
                    chk_pass++;
                else
                    $display("FAIL event: got lib=%0b dev=%0b rej=%0b val=%0d, expected lib=%0b dev=%0b rej=%0b val=%0d",
                             got.lib, got.dev, got.rej, got.val, expv.lib, expv.dev, expv.rej, expv.val);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        chk_total++;
        if (actual === required)
            chk_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, actual, required);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [3:0] v);
        moedaValida = 1'b1; valorMoeda = v;
        tick();
        moedaValida = 1'b0; valorMoeda = '0;
    endtask

    task automatic sel(input logic [2:0] p);
        selecionar = 1'b1; valorProduto = p;
        tick();
        selecionar = 1'b0; valorProduto = '0;
    endtask

    task automatic coin_sel(input logic [3:0] v, input logic [2:0] p);
        moedaValida = 1'b1; valorMoeda = v; selecionar = 1'b1; valorProduto = p;
        tick();
        moedaValida = 1'b0; valorMoeda = '0; selecionar = 1'b0; valorProduto = '0;
    endtask

    task automatic cancel();
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(q.size()), 0);
        q.delete();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_total", valorTotal, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_outputs", {liberarProduto, devolverMoedas, moedaRejeitada}, 0);
        check("rst_devolvido", valorDevolvido, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // Exact payment, product 1 (price 2), with latency check.
        q.push_back(ev(1, 0, 0, 0));
        coin(2);
        check("acc_total_2", valorTotal, 2);
        sel(1);
        check("cmp_ocupado", ocupado, 1);
        check("cmp_no_lib", liberarProduto, 0);
        tick();
        check("lib_latency", liberarProduto, 1);
        drain("exact_p1");
        check("cleared_p1", valorTotal, 0);

        // 4+4 on product 6 (price 8).
        q.push_back(ev(1, 0, 0, 0));
        coin(4); coin(4);
        check("acc_total_8", valorTotal, 8);
        sel(6);
        drain("exact_p6");

        // Underpayment: 5 on product 6.
        q.push_back(ev(0, 1, 0, 5));
        coin(5); sel(6);
        drain("under_p6");

        // Overpayment: 9 on product 3 (price 5), 8 on product 1 (price 2).
`ifdef TROCO_EN
        q.push_back(ev(1, 1, 0, 4));
`else
        q.push_back(ev(0, 1, 0, 9));
`endif
        coin(9); sel(3);
        drain("over_p3");
`ifdef TROCO_EN
        q.push_back(ev(1, 1, 0, 6));
`else
        q.push_back(ev(0, 1, 0, 8));
`endif
        coin(8); sel(1);
        drain("over_p1");

        // Timeout return after TIMEOUT idle cycles.
        q.push_back(ev(0, 1, 0, 3));
        coin(3);
        repeat (TIMEOUT) @(negedge clk);
        check("timeout_not_early", devolverMoedas, 0);
        check("timeout_total_kept", valorTotal, 3);
        drain("timeout");
        check("timeout_cleared", valorTotal, 0);

        // Cancel.
        q.push_back(ev(0, 1, 0, 3));
        coin(3); cancel();
        check("cancel_ocupado", ocupado, 1);
        drain("cancel");

        // Overflow: build 250, then a coin of 10 is rejected.
        for (int i = 0; i < 16; i++) coin(15);
        coin(10);
        check("ovf_total_250", valorTotal, 250);
        q.push_back(ev(0, 0, 1, 0));
        coin(10);
        drain("ovf_reject");
        check("ovf_total_kept", valorTotal, 250);
        q.push_back(ev(0, 1, 0, 250));
        cancel();
        drain("ovf_cancel");

        // Coin during COMPARANDO rejected, rejection pulse lands with the release.
        q.push_back(ev(1, 0, 1, 0));
        coin(2); sel(1); coin(5);
        drain("busy_coin");
        check("busy_total", valorTotal, 0);

        // Invalid product codes return full credit.
        q.push_back(ev(0, 1, 0, 4));
        coin(4); sel(7);
        drain("code7");
        q.push_back(ev(0, 1, 0, 3));
        coin(3); sel(0);
        drain("code0");

        // Select with no credit in OCIOSO is ignored; cancel too.
        sel(1); cancel();
        check("idle_sel_ignored", ocupado, 0);

        // Async reset in ACUMULANDO.
        coin(6);
        check("pre_rst_total", valorTotal, 6);
        reset = 1'b0;
        #1;
        check("midrst_total", valorTotal, 0);
        check("midrst_outputs", {ocupado, liberarProduto, devolverMoedas, moedaRejeitada}, 0);
        check("midrst_devolvido", valorDevolvido, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("post_rst_total", valorTotal, 0);

        // Same-cycle coin and select from OCIOSO.
        q.push_back(ev(1, 0, 0, 0));
        coin_sel(2, 1);
        drain("coin_sel_idle");
        // Same-cycle coin and select in ACUMULANDO: 2+3 against price 5.
        q.push_back(ev(1, 0, 0, 0));
        coin(2); coin_sel(3, 3);
        drain("coin_sel_acc");

        repeat (3) tick();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
